// File: rtl/ac97_pkg.sv
// rtl/ac97_pkg.sv - shared AC-97 frame geometry, tag positions and command record
package ac97_pkg;

  localparam int FRAME_BITS = 256;
  localparam int SLOT_BITS  = 20;

  // First bit_count of each slot; SLOT_END is the first bit after slot 4
  localparam int SLOT1    = 16;
  localparam int SLOT2    = 36;
  localparam int SLOT3    = 56;
  localparam int SLOT4    = 76;
  localparam int SLOT_END = 96;

  // Tag positions counted in transmit order (bit 0 is sent first)
  localparam int TAG_VALID       = 0;
  localparam int TAG_SLOT1       = 1;
  localparam int TAG_SLOT2       = 2;
  localparam int TAG_SLOT3       = 3;
  localparam int TAG_SLOT4       = 4;
  localparam int TAG_CODEC_READY = 0;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] data;
  } ac97_cmd_t;

  // Slot 0 word with its first-sent bit in the MSB
  function automatic logic [15:0] tag_word(input logic cmd);
    logic [15:0] w;
    w = '0;
    w[15-TAG_VALID] = 1'b1;
    w[15-TAG_SLOT1] = cmd;
    w[15-TAG_SLOT2] = cmd;
    w[15-TAG_SLOT3] = 1'b1;
    w[15-TAG_SLOT4] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/ac97_frame_counter.sv
// rtl/ac97_frame_counter.sv - bit counter producing sync, frame load and ready strobe
module ac97_frame_counter #(
  parameter int FRAME_BITS = 256,
  parameter int READY_BIT  = 128
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] bit_count,
  output logic [7:0] bit_next,
  output logic       sync,
  output logic       frame_load,
  output logic       capture_load,
  output logic       ready
);

  localparam logic [7:0] LAST     = 8'(FRAME_BITS - 1);
  localparam logic [7:0] READY_AT = 8'(READY_BIT);
  localparam logic [7:0] SYNC_END = 8'(ac97_pkg::SLOT1);

  always_comb begin
    bit_next = (bit_count == LAST) ? 8'd0 : bit_count + 8'd1;
  end

  assign frame_load   = !reset && (bit_count == LAST);
  assign capture_load = !reset && (bit_next == READY_AT);

  // sync and ready are registered from the next count so they line up with bit_count
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_count <= LAST;
      sync      <= 1'b0;
      ready     <= 1'b0;
    end else begin
      bit_count <= bit_next;
      sync      <= (bit_next < SYNC_END);
      ready     <= (bit_next == READY_AT);
    end
  end

endmodule

// File: rtl/ac97_link.sv
// rtl/ac97_link.sv - AC-97 controller link: frame serializer, slot 3/4 capture, command holder
module ac97_link import ac97_pkg::*; #(
  parameter int FRAME_BITS = 256,
  parameter int READY_BIT  = 128
) (
  input  logic        clock,
  input  logic        reset,
  output logic        ac97_sync,
  output logic        ac97_sdata_out,
  input  logic        ac97_sdata_in,
  output logic        ready,
  output logic        codec_ready,
  input  logic [19:0] left_in,
  input  logic [19:0] right_in,
  output logic [19:0] left_out,
  output logic [19:0] right_out,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_data
);

  localparam logic [7:0] TX_END  = 8'(SLOT_END);
  localparam logic [7:0] L_FIRST = 8'(SLOT3 + 1);
  localparam logic [7:0] L_LAST  = 8'(SLOT4);
  localparam logic [7:0] R_FIRST = 8'(SLOT4 + 1);
  localparam logic [7:0] R_LAST  = 8'(SLOT_END);
  localparam logic [7:0] TAG_AT  = 8'(TAG_CODEC_READY + 1);

  logic [7:0]  bit_count;
  logic [7:0]  bit_next;
  logic        frame_load;
  logic        capture_load;

  ac97_cmd_t   cmd_hold;
  logic        pending;
  ac97_cmd_t   slot_cmd;
  logic        cmd_present;
  logic [19:0] tx_left;
  logic [19:0] tx_right;
  logic [19:0] rx_left_sr;
  logic [19:0] rx_right_sr;
  logic [0:SLOT_END-1] tx_frame;

  ac97_frame_counter #(
    .FRAME_BITS (FRAME_BITS),
    .READY_BIT  (READY_BIT)
  ) u_counter (
    .clock        (clock),
    .reset        (reset),
    .bit_count    (bit_count),
    .bit_next     (bit_next),
    .sync         (ac97_sync),
    .frame_load   (frame_load),
    .capture_load (capture_load),
    .ready        (ready)
  );

  assign cmd_ready = !pending;

  // Slots 0..4 in transmit order; everything past slot 4 is sent as zero
  assign tx_frame = {tag_word(cmd_present),
                     1'b0, slot_cmd.addr, 12'b0,
                     slot_cmd.data, 4'b0,
                     tx_left, tx_right};

  always_ff @(posedge clock) begin
    if (reset) begin
      ac97_sdata_out <= 1'b0;
    end else begin
      ac97_sdata_out <= (bit_next < TX_END) ? tx_frame[bit_next[6:0]] : 1'b0;
    end
  end

  // A command accepted on the load cycle misses this frame and goes out in the next
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_hold    <= '0;
      pending     <= 1'b0;
      slot_cmd    <= '0;
      cmd_present <= 1'b0;
      tx_left     <= '0;
      tx_right    <= '0;
    end else begin
      if (frame_load) begin
        tx_left     <= left_in;
        tx_right    <= right_in;
        cmd_present <= pending;
        if (pending) begin
          slot_cmd <= cmd_hold;
          pending  <= 1'b0;
        end else begin
          slot_cmd <= '0;
        end
      end
      if (cmd_valid && !pending) begin
        cmd_hold.addr <= cmd_addr;
        cmd_hold.data <= cmd_data;
        pending       <= 1'b1;
      end
    end
  end

  // The codec's bit k arrives one count late, so slot windows are shifted by one
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_left_sr  <= '0;
      rx_right_sr <= '0;
      codec_ready <= 1'b0;
      left_out    <= '0;
      right_out   <= '0;
    end else begin
      if (bit_count == TAG_AT) begin
        codec_ready <= ac97_sdata_in;
      end
      if (bit_count >= L_FIRST && bit_count <= L_LAST) begin
        rx_left_sr <= {rx_left_sr[18:0], ac97_sdata_in};
      end
      if (bit_count >= R_FIRST && bit_count <= R_LAST) begin
        rx_right_sr <= {rx_right_sr[18:0], ac97_sdata_in};
      end
      if (capture_load) begin
        left_out  <= rx_left_sr;
        right_out <= rx_right_sr;
      end
    end
  end

endmodule
